// File: rtl/shader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shader_pkg
//  Brief    : Shared types and constants for the shader program loader
//             (loader FSM states, error codes, default widths).
//  Revision : 1.0  initial release
// ============================================================================
package shader_pkg;

    // Widths shared with shader_pipeline
    localparam int unsigned SHADER_ADDR_WIDTH  = 8;
    localparam int unsigned SHADER_INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CHECK   = 2'd2,
        RELEASE = 2'd3
    } loader_state_t;

    // Result of the most recent load attempt
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// ============================================================================
//  Module   : loader_checksum
//  Brief    : Running modular (wrap-around) sum of accepted program words.
//             clear has priority over enable.
//  Revision : 1.0  initial release
// ============================================================================
module loader_checksum
    import shader_pkg::*;
#(
    parameter int unsigned WIDTH = SHADER_INSTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] r_sum;

    // Accumulate each accepted word; carries out of the top bit are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (clear) begin
            r_sum <= '0;
        end else if (enable) begin
            r_sum <= r_sum + data;
        end
    end

    assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/shader_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : shader_program_loader
//  Brief    : Streams a program into shader imem at a base address, verifies
//             its additive checksum, then releases the pipeline from hold and
//             pulses core_start with start_pc = base.
//  Revision : 1.0  initial release
// ============================================================================
module shader_program_loader
    import shader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = SHADER_ADDR_WIDTH,
    parameter int unsigned INSTR_WIDTH = SHADER_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH-1:0]  load_base,
    input  logic [ADDR_WIDTH:0]    load_len,
    input  logic [INSTR_WIDTH-1:0] load_csum,
    input  logic                   load_abort,
    input  logic [INSTR_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_hold,
    output logic                   core_start,
    output logic [ADDR_WIDTH-1:0]  start_pc,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err_code
);

    // One past the last imem address; a load may end exactly here
    localparam logic [ADDR_WIDTH+1:0] c_depth = {2'b01, {ADDR_WIDTH{1'b0}}};

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_base;
    logic [ADDR_WIDTH:0]    r_len;
    logic [ADDR_WIDTH:0]    r_cnt;
    logic [INSTR_WIDTH-1:0] r_csum;
    logic [INSTR_WIDTH-1:0] w_sum;

    logic                   r_imem_we;
    logic [ADDR_WIDTH-1:0]  r_imem_addr;
    logic [INSTR_WIDTH-1:0] r_imem_wdata;

    logic                   r_core_hold,  w_core_hold_nxt;
    logic                   r_core_start, w_core_start_nxt;
    logic [ADDR_WIDTH-1:0]  r_start_pc,   w_start_pc_nxt;
    logic                   r_done,       w_done_nxt;
    logic [1:0]             r_err,        w_err_nxt;

    logic                   w_ready;
    logic                   w_latch;
    logic                   w_xfer;
    logic [ADDR_WIDTH+1:0]  w_load_end;
    logic                   w_bad_len;

    // Reject empty programs and any program that would run past the top of imem
    assign w_load_end = {2'b00, load_base} + {1'b0, load_len};
    assign w_bad_len  = (load_len == '0) || (w_load_end > c_depth);

    // A word coinciding with abort is neither written nor summed
    assign w_xfer = s_valid & w_ready & ~load_abort;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and next values of the registered status outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_core_hold_nxt  = r_core_hold;
        w_core_start_nxt = 1'b0;
        w_start_pc_nxt   = r_start_pc;
        w_done_nxt       = 1'b0;
        w_err_nxt        = r_err;
        w_ready          = 1'b0;
        w_latch          = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_latch = 1'b1;
                    if (w_bad_len) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = ERR_BAD_LEN;
                    end else begin
                        w_err_nxt       = ERR_OK;
                        w_core_hold_nxt = 1'b1;
                        w_state_nxt     = LOAD;
                    end
                end
            end
            LOAD: begin
                w_ready = (r_cnt < r_len);
                if (load_abort) begin
                    w_state_nxt     = IDLE;
                    w_done_nxt      = 1'b1;
                    w_err_nxt       = ERR_ABORT;
                    w_core_hold_nxt = 1'b1;
                end else if (r_cnt == r_len) begin
                    // Last word is being written this cycle
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (load_abort) begin
                    w_state_nxt     = IDLE;
                    w_done_nxt      = 1'b1;
                    w_err_nxt       = ERR_ABORT;
                    w_core_hold_nxt = 1'b1;
                end else if (w_sum == r_csum) begin
                    w_state_nxt      = RELEASE;
                    w_done_nxt       = 1'b1;
                    w_err_nxt        = ERR_OK;
                    w_core_hold_nxt  = 1'b0;
                    w_core_start_nxt = 1'b1;
                    w_start_pc_nxt   = r_base;
                end else begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = ERR_CSUM;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered status outputs; pipeline stays held out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_hold  <= 1'b1;
            r_core_start <= 1'b0;
            r_start_pc   <= '0;
            r_done       <= 1'b0;
            r_err        <= ERR_OK;
        end else begin
            r_core_hold  <= w_core_hold_nxt;
            r_core_start <= w_core_start_nxt;
            r_start_pc   <= w_start_pc_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    // Load parameters, word counter and the one-cycle imem write stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base       <= '0;
            r_len        <= '0;
            r_csum       <= '0;
            r_cnt        <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
        end else begin
            r_imem_we <= w_xfer;
            if (w_latch) begin
                r_base <= load_base;
                r_len  <= load_len;
                r_csum <= load_csum;
                r_cnt  <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_xfer) begin
                r_imem_addr  <= r_base + r_cnt[ADDR_WIDTH-1:0];
                r_imem_wdata <= s_data;
            end
        end
    end

    loader_checksum #(
        .WIDTH (INSTR_WIDTH)
    ) u_checksum (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_latch),
        .enable (w_xfer),
        .data   (s_data),
        .sum    (w_sum)
    );

    assign s_ready    = w_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign core_hold  = r_core_hold;
    assign core_start = r_core_start;
    assign start_pc   = r_start_pc;
    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign err_code   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shader_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shader_program_loader
//  Brief    : Self-checking bench: table of load transactions with expected
//             results, plus hand sequences for reset, idle abort and
//             reset in the middle of a load.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shader_program_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_base;
    logic [8:0]  load_len;
    logic [31:0] load_csum;
    logic        load_abort;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        core_start;
    logic [7:0]  start_pc;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]       base;
        logic [8:0]       len;
        logic [31:0]      csum;
        logic [3:0][31:0] words;
        bit               toggle;     // s_valid alternates 1/0
        int               abort_at;   // abort together with this word index
        logic [1:0]       exp_err;
        int               exp_writes;
        int               exp_start;
        int               exp_busy;   // cycles with busy=1
        logic             exp_hold;   // core_hold after the attempt
    } vec_t;

    vec_t vecs[8];

    shader_program_loader #(
        .ADDR_WIDTH  (8),
        .INSTR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .load_csum  (load_csum),
        .load_abort (load_abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .core_start (core_start),
        .start_pc   (start_pc),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [8:0] l, input logic [31:0] cs,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input bit tg, input int ab, input logic [1:0] er,
                                input int wr, input int st, input int bs, input logic hd);
        vec_t v;
        v.base = b; v.len = l; v.csum = cs;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
        v.toggle = tg; v.abort_at = ab; v.exp_err = er;
        v.exp_writes = wr; v.exp_start = st; v.exp_busy = bs; v.exp_hold = hd;
        return v;
    endfunction

    // Drive one load attempt and check everything observed until it settles
    task automatic run_vec(input int id, input vec_t v);
        int         widx = 0;
        int         wr = 0;
        int         dn = 0;
        int         st = 0;
        int         bsy = 0;
        int         cyc = 0;
        int         post = -1;
        logic [1:0] err_at_done = 2'd0;
        logic [7:0] pc_at_start = 8'd0;
        logic       hold_at_start = 1'b1;
        logic [7:0]  wa[4];
        logic [31:0] wd[4];
        string      tag;
        tag = $sformatf("v%0d", id);
        @(negedge clk);
        load_start = 1'b1;
        load_base  = v.base;
        load_len   = v.len;
        load_csum  = v.csum;
        load_abort = 1'b0;
        s_valid    = 1'b0;
        while (post != 0 && cyc < 60) begin
            @(negedge clk);
            load_start = 1'b0;
            load_abort = 1'b0;
            s_valid    = 1'b0;
            cyc++;
            if (busy) bsy++;
            if (imem_we) begin
                if (wr < 4) begin
                    wa[wr] = imem_addr;
                    wd[wr] = imem_wdata;
                end
                wr++;
            end
            if (done) begin
                dn++;
                err_at_done = err_code;
                if (post < 0) post = 3;
            end
            if (core_start) begin
                st++;
                pc_at_start   = start_pc;
                hold_at_start = core_hold;
            end
            if (post > 0) post--;
            if (s_ready && widx < int'(v.len) && post < 0) begin
                s_valid = v.toggle ? (cyc % 2 == 1) : 1'b1;
                s_data  = v.words[widx[1:0]];
                if (s_valid) begin
                    if (widx == v.abort_at) load_abort = 1'b1;
                    else widx++;
                end
            end
        end
        chk({tag, " done_pulses"}, 32'(dn), 32'd1);
        chk({tag, " err_at_done"}, 32'(err_at_done), 32'(v.exp_err));
        chk({tag, " err_held"}, 32'(err_code), 32'(v.exp_err));
        chk({tag, " imem_writes"}, 32'(wr), 32'(v.exp_writes));
        chk({tag, " core_start_pulses"}, 32'(st), 32'(v.exp_start));
        chk({tag, " busy_cycles"}, 32'(bsy), 32'(v.exp_busy));
        chk({tag, " core_hold"}, 32'(core_hold), 32'(v.exp_hold));
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " s_ready_end"}, 32'(s_ready), 32'd0);
        if (v.exp_start > 0) begin
            chk({tag, " start_pc"}, 32'(pc_at_start), 32'(v.base));
            chk({tag, " hold_at_start"}, 32'(hold_at_start), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < wr && i < v.exp_writes) begin
                chk($sformatf("%s addr%0d", tag, i), 32'(wa[i]), 32'(v.base + 8'(i)));
                chk($sformatf("%s data%0d", tag, i), wd[i], v.words[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_base  = 8'd0;
        load_len   = 9'd0;
        load_csum  = 32'd0;
        load_abort = 1'b0;
        s_data     = 32'd0;
        s_valid    = 1'b0;

        //          base    len    csum          w0            w1     w2     w3     tg ab  err wr st busy hold
        vecs[0] = mk(8'h10, 9'd4, 32'h0000000A, 32'd1,        32'd2, 32'd3, 32'd4, 0, 99, 2'd0, 4, 1, 7, 1'b0);
        vecs[1] = mk(8'hFE, 9'd3, 32'h00000000, 32'd1,        32'd2, 32'd3, 32'd0, 0, 99, 2'd1, 0, 0, 0, 1'b0);
        vecs[2] = mk(8'h00, 9'd0, 32'h00000000, 32'd1,        32'd2, 32'd3, 32'd4, 0, 99, 2'd1, 0, 0, 0, 1'b0);
        vecs[3] = mk(8'h10, 9'd4, 32'h0000000A, 32'd1,        32'd2, 32'd3, 32'd4, 1, 99, 2'd0, 4, 1, 10, 1'b0);
        vecs[4] = mk(8'h30, 9'd3, 32'h0000DEAD, 32'd5,        32'd6, 32'd7, 32'd0, 0, 99, 2'd2, 3, 0, 5, 1'b1);
        vecs[5] = mk(8'h40, 9'd4, 32'h0000001E, 32'd9,        32'd8, 32'd7, 32'd6, 0, 2,  2'd3, 2, 0, 3, 1'b1);
        vecs[6] = mk(8'hFC, 9'd4, 32'h00000001, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 0, 99, 2'd0, 4, 1, 7, 1'b0);
        vecs[7] = mk(8'h80, 9'd2, 32'h00000033, 32'h11,       32'h22, 32'd0, 32'd0, 0, 99, 2'd0, 2, 1, 5, 1'b0);

        // Reset values after two reset cycles
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst core_hold", 32'(core_hold), 32'd1);
        chk("rst s_ready", 32'(s_ready), 32'd0);
        chk("rst imem_we", 32'(imem_we), 32'd0);
        chk("rst err_code", 32'(err_code), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst core_start", 32'(core_start), 32'd0);
        chk("rst start_pc", 32'(start_pc), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            run_vec(k, vecs[k]);
        end

        // Abort while idle is ignored
        @(negedge clk);
        load_abort = 1'b1;
        @(negedge clk);
        load_abort = 1'b0;
        chk("idle_abort done", 32'(done), 32'd0);
        chk("idle_abort busy", 32'(busy), 32'd0);
        chk("idle_abort err", 32'(err_code), 32'd0);

        // Reset in the middle of a load
        @(negedge clk);
        load_start = 1'b1;
        load_base  = 8'h50;
        load_len   = 9'd4;
        load_csum  = 32'd0;
        @(negedge clk);
        load_start = 1'b0;
        s_valid    = 1'b1;
        s_data     = 32'h111;
        @(negedge clk);
        s_data     = 32'h222;
        @(negedge clk);
        chk("midrst busy_before", 32'(busy), 32'd1);
        chk("midrst we_before", 32'(imem_we), 32'd1);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("midrst core_hold", 32'(core_hold), 32'd1);
        chk("midrst s_ready", 32'(s_ready), 32'd0);
        chk("midrst imem_we", 32'(imem_we), 32'd0);
        chk("midrst imem_addr", 32'(imem_addr), 32'd0);
        chk("midrst imem_wdata", imem_wdata, 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst core_start", 32'(core_start), 32'd0);
        chk("midrst start_pc", 32'(start_pc), 32'd0);
        chk("midrst err_code", 32'(err_code), 32'd0);
        rst = 1'b0;

        // A fresh load after reset starts from a clean counter and checksum
        run_vec(7, vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
